// File: rtl/lsu_axi_master_pkg.sv
// rtl/lsu_axi_master_pkg.sv - shared AXI encodings, FSM states and lane helpers for the LSU bus master
package lsu_axi_master_pkg;

    localparam logic [2:0] AXI_ADDR_SIZE_1 = 3'b000;
    localparam logic [2:0] AXI_ADDR_SIZE_2 = 3'b001;
    localparam logic [2:0] AXI_ADDR_SIZE_4 = 3'b010;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WREQ  = 3'd3,
        ST_WRESP = 3'd4,
        ST_DONE  = 3'd5
    } lsu_state_t;

    typedef enum logic [1:0] {
        LANE_BYTE = 2'd0,
        LANE_HALF = 2'd1,
        LANE_WORD = 2'd2
    } lane_width_t;

    // Encodings above word size have no meaning on a 32-bit bus and collapse to word.
    function automatic lane_width_t size_to_width(input logic [2:0] size);
        lane_width_t width;
        case (size)
            AXI_ADDR_SIZE_1: width = LANE_BYTE;
            AXI_ADDR_SIZE_2: width = LANE_HALF;
            default:         width = LANE_WORD;
        endcase
        return width;
    endfunction

    function automatic logic [2:0] normalize_size(input logic [2:0] size);
        return (size > AXI_ADDR_SIZE_4) ? AXI_ADDR_SIZE_4 : size;
    endfunction

endpackage

// File: rtl/lsu_axi_master_if.sv
// rtl/lsu_axi_master_if.sv - AR/R/AW/W/B data channels between the LSU and the AXI controller
interface lsu_axi_master_if #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
);

    logic [ADDR_LEN-1:0] data_addr_r_addr;
    logic [2:0]          data_addr_r_size;
    logic                data_addr_r_valid;
    logic                data_addr_r_ready;

    logic [DATA_LEN-1:0] data_r_data;
    logic [1:0]          data_r_resp;
    logic                data_r_valid;
    logic                data_r_ready;

    logic [ADDR_LEN-1:0] data_addr_w_addr;
    logic [2:0]          data_addr_w_size;
    logic                data_addr_w_valid;
    logic                data_addr_w_ready;

    logic [DATA_LEN-1:0] data_w_data;
    logic [3:0]          data_w_strb;
    logic                data_w_valid;
    logic                data_w_ready;

    logic [1:0]          data_bkwd_resp;
    logic                data_bkwd_valid;
    logic                data_bkwd_ready;

    modport master (
        output data_addr_r_addr, data_addr_r_size, data_addr_r_valid,
        input  data_addr_r_ready,
        input  data_r_data, data_r_resp, data_r_valid,
        output data_r_ready,
        output data_addr_w_addr, data_addr_w_size, data_addr_w_valid,
        input  data_addr_w_ready,
        output data_w_data, data_w_strb, data_w_valid,
        input  data_w_ready,
        input  data_bkwd_resp, data_bkwd_valid,
        output data_bkwd_ready
    );

    modport slave (
        input  data_addr_r_addr, data_addr_r_size, data_addr_r_valid,
        output data_addr_r_ready,
        output data_r_data, data_r_resp, data_r_valid,
        input  data_r_ready,
        input  data_addr_w_addr, data_addr_w_size, data_addr_w_valid,
        output data_addr_w_ready,
        input  data_w_data, data_w_strb, data_w_valid,
        output data_w_ready,
        output data_bkwd_resp, data_bkwd_valid,
        input  data_bkwd_ready
    );

endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane replication, strobes, load extraction/extension and misalignment flag
module lsu_lane_align
    import lsu_axi_master_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        load_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] load_raw,
    output logic [31:0] store_lanes,
    output logic [3:0]  store_strb,
    output logic [31:0] load_data,
    output logic        misaligned
);

    lane_width_t width;
    logic [31:0] shifted;
    logic        sign_fill;

    // Decode lane placement for both directions from size and the low address bits.
    always_comb begin
        width       = size_to_width(size);
        shifted     = load_raw >> {addr_lo, 3'b000};
        sign_fill   = 1'b0;
        store_lanes = store_data;
        store_strb  = 4'b1111;
        load_data   = shifted;
        misaligned  = 1'b0;
        case (width)
            LANE_BYTE: begin
                sign_fill   = ~load_unsigned & shifted[7];
                store_lanes = {4{store_data[7:0]}};
                store_strb  = 4'b0001 << addr_lo;
                load_data   = {{24{sign_fill}}, shifted[7:0]};
            end
            LANE_HALF: begin
                sign_fill   = ~load_unsigned & shifted[15];
                store_lanes = {2{store_data[15:0]}};
                store_strb  = 4'b0011 << addr_lo;
                load_data   = {{16{sign_fill}}, shifted[15:0]};
                misaligned  = addr_lo[0];
            end
            default: begin
                misaligned  = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/lsu_axi_master.sv
// rtl/lsu_axi_master.sv - load/store unit master issuing single-beat AXI reads and writes
module lsu_axi_master
    import lsu_axi_master_pkg::*;
#(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_wen_i,
    input  logic [ADDR_LEN-1:0] req_addr_i,
    input  logic [DATA_LEN-1:0] req_wdata_i,
    input  logic [2:0]          req_size_i,
    input  logic                req_unsigned_i,
    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic [DATA_LEN-1:0] resp_rdata_o,
    output logic                resp_err_o,
    lsu_axi_master_if.master    bus
);

    lsu_state_t state;

    logic [1:0]  lat_addr_lo;
    logic [2:0]  lat_size;
    logic        lat_unsigned;

    logic [2:0]  align_size;
    logic [1:0]  align_addr_lo;
    logic        align_unsigned;
    logic [31:0] store_lanes;
    logic [3:0]  store_strb;
    logic [31:0] load_data;
    logic        misaligned;
    logic [2:0]  req_size_norm;

    // In IDLE the aligner looks at the incoming request (store lanes, misalignment);
    // afterwards it uses the latched request so loads extract the right lane.
    always_comb begin
        req_size_norm  = normalize_size(req_size_i);
        align_size     = (state == ST_IDLE) ? req_size_norm  : lat_size;
        align_addr_lo  = (state == ST_IDLE) ? req_addr_i[1:0] : lat_addr_lo;
        align_unsigned = (state == ST_IDLE) ? req_unsigned_i  : lat_unsigned;
    end

    lsu_lane_align u_lane_align (
        .size          (align_size),
        .addr_lo       (align_addr_lo),
        .load_unsigned (align_unsigned),
        .store_data    (req_wdata_i),
        .load_raw      (bus.data_r_data),
        .store_lanes   (store_lanes),
        .store_strb    (store_strb),
        .load_data     (load_data),
        .misaligned    (misaligned)
    );

    // Request FSM; every bus and response output is a register updated here.
    always_ff @(posedge clock) begin
        if (reset) begin
            state                 <= ST_IDLE;
            lat_addr_lo           <= '0;
            lat_size              <= '0;
            lat_unsigned          <= 1'b0;
            req_ready_o           <= 1'b1;
            resp_valid_o          <= 1'b0;
            resp_rdata_o          <= '0;
            resp_err_o            <= 1'b0;
            bus.data_addr_r_addr  <= '0;
            bus.data_addr_r_size  <= '0;
            bus.data_addr_r_valid <= 1'b0;
            bus.data_r_ready      <= 1'b0;
            bus.data_addr_w_addr  <= '0;
            bus.data_addr_w_size  <= '0;
            bus.data_addr_w_valid <= 1'b0;
            bus.data_w_data       <= '0;
            bus.data_w_strb       <= '0;
            bus.data_w_valid      <= 1'b0;
            bus.data_bkwd_ready   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        req_ready_o  <= 1'b0;
                        lat_addr_lo  <= req_addr_i[1:0];
                        lat_size     <= req_size_norm;
                        lat_unsigned <= req_unsigned_i;
                        if (misaligned) begin
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                            resp_rdata_o <= '0;
                            state        <= ST_DONE;
                        end else if (req_wen_i) begin
                            bus.data_addr_w_addr  <= req_addr_i;
                            bus.data_addr_w_size  <= req_size_norm;
                            bus.data_addr_w_valid <= 1'b1;
                            bus.data_w_data       <= store_lanes;
                            bus.data_w_strb       <= store_strb;
                            bus.data_w_valid      <= 1'b1;
                            state                 <= ST_WREQ;
                        end else begin
                            bus.data_addr_r_addr  <= req_addr_i;
                            bus.data_addr_r_size  <= req_size_norm;
                            bus.data_addr_r_valid <= 1'b1;
                            state                 <= ST_RADDR;
                        end
                    end
                end
                ST_RADDR: begin
                    if (bus.data_addr_r_ready) begin
                        bus.data_addr_r_valid <= 1'b0;
                        bus.data_r_ready      <= 1'b1;
                        state                 <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (bus.data_r_valid) begin
                        bus.data_r_ready <= 1'b0;
                        resp_rdata_o     <= load_data;
                        resp_err_o       <= (bus.data_r_resp != AXI_RESP_OKAY);
                        resp_valid_o     <= 1'b1;
                        state            <= ST_DONE;
                    end
                end
                ST_WREQ: begin
                    // AW and W retire independently; move on once neither is still pending.
                    if (bus.data_addr_w_valid && bus.data_addr_w_ready) begin
                        bus.data_addr_w_valid <= 1'b0;
                    end
                    if (bus.data_w_valid && bus.data_w_ready) begin
                        bus.data_w_valid <= 1'b0;
                    end
                    if ((!bus.data_addr_w_valid || bus.data_addr_w_ready) &&
                        (!bus.data_w_valid || bus.data_w_ready)) begin
                        bus.data_bkwd_ready <= 1'b1;
                        state               <= ST_WRESP;
                    end
                end
                ST_WRESP: begin
                    if (bus.data_bkwd_valid) begin
                        bus.data_bkwd_ready <= 1'b0;
                        resp_rdata_o        <= '0;
                        resp_err_o          <= (bus.data_bkwd_resp != AXI_RESP_OKAY);
                        resp_valid_o        <= 1'b1;
                        state               <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        req_ready_o  <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    req_ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_axi_master.sv
// tb/tb_lsu_axi_master.sv - self-checking bench for lsu_axi_master
module tb_lsu_axi_master;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_wen = 1'b0, req_unsigned = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0, resp_rdata;
    logic [2:0]  req_size = '0;
    logic        resp_valid, resp_ready = 1'b0, resp_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    lsu_axi_master_if #(.ADDR_LEN(32), .DATA_LEN(32)) bus ();

    lsu_axi_master #(.ADDR_LEN(32), .DATA_LEN(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_wen_i      (req_wen),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .resp_valid_o   (resp_valid),
        .resp_ready_i   (resp_ready),
        .resp_rdata_o   (resp_rdata),
        .resp_err_o     (resp_err),
        .bus            (bus)
    );

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic        uns;
        logic [31:0] sdata;
        logic [1:0]  rresp;
        logic [1:0]  bresp;
        int          ar_d, r_d, aw_d, w_d, b_d, hold;
    } txn_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          ar_hs, aw_hs, w_hs;
        int          ar_first, aw_first, w_first;
        logic [31:0] ar_addr, aw_addr, w_data;
        logic [2:0]  ar_size, aw_size;
        logic [3:0]  w_strb;
        int          proto_bad;
        logic        end_ok;
        logic        timeout;
    } res_t;

    typedef struct {
        txn_t        t;
        logic [31:0] e_rdata;
        logic        e_err;
        int          e_lat;
        logic [31:0] e_wdata;
        logic [3:0]  e_strb;
        logic [2:0]  e_size;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    // Reference model: plain arithmetic over byte counts, independent of bus encodings.
    function automatic int ref_bytes(input logic [2:0] size);
        return (size == 3'd0) ? 1 : (size == 3'd1) ? 2 : 4;
    endfunction

    function automatic logic ref_mis(input logic [31:0] addr, input int n);
        return (int'(addr[1:0]) % n) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input int n,
                                            input logic uns, input logic [31:0] raw);
        longint v, m;
        v = longint'(raw >> (8 * int'(addr[1:0])));
        m = longint'(1) << (8 * n);
        v = v % m;
        if (!uns && v >= m / 2) v = v - m;
        return v[31:0];
    endfunction

    function automatic logic [3:0] ref_strb(input logic [31:0] addr, input int n);
        logic [3:0] s;
        s = '0;
        for (int k = 0; k < 4; k++)
            if (k >= int'(addr[1:0]) && k < int'(addr[1:0]) + n) s[k] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] d, input int n);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = d[8*(k % n) +: 8];
        return w;
    endfunction

    function automatic logic [2:0] ref_size(input int n);
        return (n == 1) ? 3'd0 : (n == 2) ? 3'd1 : 3'd2;
    endfunction

    function automatic vec_t mkv(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [2:0] size, input logic uns, input logic [31:0] sdata,
                                 input logic [1:0] rresp, input logic [1:0] bresp, input int aw_d,
                                 input int hold, input logic [31:0] e_rdata, input logic e_err,
                                 input int e_lat, input logic [31:0] e_wdata, input logic [3:0] e_strb,
                                 input logic [2:0] e_size);
        vec_t v;
        v.t.wen = wen;     v.t.addr = addr;   v.t.wdata = wdata; v.t.size = size;
        v.t.uns = uns;     v.t.sdata = sdata; v.t.rresp = rresp; v.t.bresp = bresp;
        v.t.ar_d = 0;      v.t.r_d = 0;       v.t.aw_d = aw_d;   v.t.w_d = 0;
        v.t.b_d = 0;       v.t.hold = hold;
        v.e_rdata = e_rdata; v.e_err = e_err; v.e_lat = e_lat;
        v.e_wdata = e_wdata; v.e_strb = e_strb; v.e_size = e_size;
        return v;
    endfunction

    task automatic idle_slave();
        bus.data_addr_r_ready = 1'b0;
        bus.data_r_valid      = 1'b0;
        bus.data_r_data       = '0;
        bus.data_r_resp       = '0;
        bus.data_addr_w_ready = 1'b0;
        bus.data_w_ready      = 1'b0;
        bus.data_bkwd_valid   = 1'b0;
        bus.data_bkwd_resp    = '0;
    endtask

    // Drives one request and plays a slave with per-channel delays, recording what it sees.
    task automatic run_txn(input txn_t t, output res_t r);
        int  ar_w, r_c, aw_w, w_w, b_c, hold_c;
        bit  ar_done, r_done, aw_done, w_done, consumed;
        bit  ar_now, r_now, aw_now, w_now, b_now, cons_now;
        r = '{default: 0};
        r.lat = -1; r.ar_first = -1; r.aw_first = -1; r.w_first = -1; r.timeout = 1'b1;
        ar_w = 0; r_c = 0; aw_w = 0; w_w = 0; b_c = 0; hold_c = 0;
        ar_done = 0; r_done = 0; aw_done = 0; w_done = 0; consumed = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clock);
            if (consumed) begin
                r.end_ok  = req_ready && !resp_valid;
                r.timeout = 1'b0;
                break;
            end
            ar_now = 0; r_now = 0; aw_now = 0; w_now = 0; b_now = 0; cons_now = 0;
            req_valid = (cyc == 0);
            if (cyc == 0) begin
                if (!req_ready) r.proto_bad++;
                req_wen = t.wen; req_addr = t.addr; req_wdata = t.wdata;
                req_size = t.size; req_unsigned = t.uns;
            end
            bus.data_addr_r_ready = 1'b0;
            if (bus.data_addr_r_valid) begin
                if (ar_done) r.proto_bad++;
                else begin
                    if (r.ar_first < 0) begin
                        r.ar_first = cyc; r.ar_addr = bus.data_addr_r_addr; r.ar_size = bus.data_addr_r_size;
                    end else if (bus.data_addr_r_addr !== r.ar_addr || bus.data_addr_r_size !== r.ar_size)
                        r.proto_bad++;
                    if (ar_w >= t.ar_d) begin bus.data_addr_r_ready = 1'b1; ar_now = 1; end
                    else ar_w++;
                end
            end else if (r.ar_first >= 0 && !ar_done) r.proto_bad++;
            bus.data_addr_w_ready = 1'b0;
            if (bus.data_addr_w_valid) begin
                if (aw_done) r.proto_bad++;
                else begin
                    if (r.aw_first < 0) begin
                        r.aw_first = cyc; r.aw_addr = bus.data_addr_w_addr; r.aw_size = bus.data_addr_w_size;
                    end else if (bus.data_addr_w_addr !== r.aw_addr || bus.data_addr_w_size !== r.aw_size)
                        r.proto_bad++;
                    if (aw_w >= t.aw_d) begin bus.data_addr_w_ready = 1'b1; aw_now = 1; end
                    else aw_w++;
                end
            end else if (r.aw_first >= 0 && !aw_done) r.proto_bad++;
            bus.data_w_ready = 1'b0;
            if (bus.data_w_valid) begin
                if (w_done) r.proto_bad++;
                else begin
                    if (r.w_first < 0) begin
                        r.w_first = cyc; r.w_data = bus.data_w_data; r.w_strb = bus.data_w_strb;
                    end else if (bus.data_w_data !== r.w_data || bus.data_w_strb !== r.w_strb)
                        r.proto_bad++;
                    if (w_w >= t.w_d) begin bus.data_w_ready = 1'b1; w_now = 1; end
                    else w_w++;
                end
            end else if (r.w_first >= 0 && !w_done) r.proto_bad++;
            bus.data_r_valid = 1'b0; bus.data_r_data = $urandom; bus.data_r_resp = 2'($urandom);
            if (ar_done && !r_done) begin
                if (r_c >= t.r_d) begin
                    bus.data_r_valid = 1'b1; bus.data_r_data = t.sdata; bus.data_r_resp = t.rresp;
                    r_now = bus.data_r_ready;
                end
                r_c++;
            end
            bus.data_bkwd_valid = 1'b0; bus.data_bkwd_resp = 2'($urandom);
            if (aw_done && w_done && b_c >= 0) begin
                if (b_c >= t.b_d && b_c < 1000) begin
                    bus.data_bkwd_valid = 1'b1; bus.data_bkwd_resp = t.bresp;
                    b_now = bus.data_bkwd_ready;
                end
                b_c++;
            end
            resp_ready = 1'b0;
            if (resp_valid) begin
                if (r.lat < 0) begin
                    r.lat = cyc; r.rdata = resp_rdata; r.err = resp_err;
                end else if (resp_rdata !== r.rdata || resp_err !== r.err) r.proto_bad++;
                if (hold_c >= t.hold) begin resp_ready = 1'b1; cons_now = 1; end
                else hold_c++;
            end
            if (ar_now) begin ar_done = 1; r.ar_hs++; end
            if (aw_now) begin aw_done = 1; r.aw_hs++; end
            if (w_now)  begin w_done = 1;  r.w_hs++;  end
            if (r_now)  r_done = 1;
            if (b_now)  b_c = 1000;
            consumed = cons_now;
        end
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        idle_slave();
    endtask

    task automatic check_result(input string tag, input txn_t t, input res_t r,
                                input logic [31:0] e_rdata, input logic e_err, input int e_lat,
                                input logic [31:0] e_wdata, input logic [3:0] e_strb,
                                input logic [2:0] e_size);
        bit mis, is_rd, is_wr;
        mis   = (e_lat == 1);
        is_rd = !t.wen && !mis;
        is_wr = t.wen && !mis;
        check({tag, ".timeout"}, 32'(r.timeout), 32'd0);
        check({tag, ".latency"}, r.lat, e_lat);
        check({tag, ".rdata"}, r.rdata, e_rdata);
        check({tag, ".err"}, 32'(r.err), 32'(e_err));
        check({tag, ".ready_after"}, 32'(r.end_ok), 32'd1);
        check({tag, ".protocol"}, r.proto_bad, 0);
        check({tag, ".ar_count"}, r.ar_hs, 32'(is_rd));
        check({tag, ".aw_count"}, r.aw_hs, 32'(is_wr));
        check({tag, ".w_count"}, r.w_hs, 32'(is_wr));
        if (is_rd) begin
            check({tag, ".ar_addr"}, r.ar_addr, t.addr);
            check({tag, ".ar_size"}, 32'(r.ar_size), 32'(e_size));
            check({tag, ".ar_cycle"}, r.ar_first, 1);
        end
        if (is_wr) begin
            check({tag, ".aw_addr"}, r.aw_addr, t.addr);
            check({tag, ".aw_size"}, 32'(r.aw_size), 32'(e_size));
            check({tag, ".aw_cycle"}, r.aw_first, 1);
            check({tag, ".w_cycle"}, r.w_first, 1);
            check({tag, ".w_data"}, r.w_data, e_wdata);
            check({tag, ".w_strb"}, 32'(r.w_strb), 32'(e_strb));
        end
    endtask

    initial begin
        vec_t vecs[$];
        res_t r;
        idle_slave();

        // Reset state, sampled while reset is still asserted.
        repeat (2) @(negedge clock);
        check("reset.req_ready", 32'(req_ready), 32'd1);
        check("reset.resp_valid", 32'(resp_valid), 32'd0);
        check("reset.resp_rdata", resp_rdata, 32'd0);
        check("reset.resp_err", 32'(resp_err), 32'd0);
        check("reset.valids", {27'd0, bus.data_addr_r_valid, bus.data_r_ready, bus.data_addr_w_valid,
                               bus.data_w_valid, bus.data_bkwd_ready}, 32'd0);
        check("reset.payload", bus.data_addr_r_addr | bus.data_addr_w_addr | bus.data_w_data |
                               {25'd0, bus.data_w_strb, bus.data_addr_r_size}, 32'd0);
        reset = 1'b0;

        //            wen  addr          wdata         sz uns sdata         rr     br     awd hold  e_rdata       err lat e_wdata       strb     size
        vecs.push_back(mkv(1, 32'h8000_0004, 32'hDEAD_BEEF, 2, 0, 32'h0,         2'b00, 2'b00, 0, 0, 32'h0,         0, 3, 32'hDEAD_BEEF, 4'b1111, 3'd2));
        vecs.push_back(mkv(0, 32'h8000_0003, 32'h0,         0, 0, 32'h80FF_0000, 2'b00, 2'b00, 0, 0, 32'hFFFF_FF80, 0, 3, 32'h0,         4'b0000, 3'd0));
        vecs.push_back(mkv(0, 32'h8000_0003, 32'h0,         0, 1, 32'h80FF_0000, 2'b00, 2'b00, 0, 0, 32'h0000_0080, 0, 3, 32'h0,         4'b0000, 3'd0));
        vecs.push_back(mkv(1, 32'h8000_0002, 32'h0000_1234, 1, 0, 32'h0,         2'b00, 2'b00, 3, 0, 32'h0,         0, 6, 32'h1234_1234, 4'b1100, 3'd1));
        vecs.push_back(mkv(0, 32'h8000_0001, 32'h0,         1, 0, 32'h1111_1111, 2'b00, 2'b00, 0, 0, 32'h0,         1, 1, 32'h0,         4'b0000, 3'd1));
        vecs.push_back(mkv(0, 32'h8000_0010, 32'h0,         2, 0, 32'h1234_5678, 2'b10, 2'b00, 0, 4, 32'h1234_5678, 1, 3, 32'h0,         4'b0000, 3'd2));
        vecs.push_back(mkv(0, 32'h0000_0042, 32'h0,         1, 0, 32'h8001_7FFF, 2'b00, 2'b00, 0, 1, 32'hFFFF_8001, 0, 3, 32'h0,         4'b0000, 3'd1));
        vecs.push_back(mkv(1, 32'h0000_0101, 32'h0000_00A5, 0, 0, 32'h0,         2'b00, 2'b11, 0, 0, 32'h0,         1, 3, 32'hA5A5_A5A5, 4'b0010, 3'd0));
        vecs.push_back(mkv(0, 32'h0000_0008, 32'h0,         3, 0, 32'hCAFE_F00D, 2'b00, 2'b00, 0, 0, 32'hCAFE_F00D, 0, 3, 32'h0,         4'b0000, 3'd2));
        vecs.push_back(mkv(1, 32'h0000_0002, 32'h5555_AAAA, 2, 0, 32'h0,         2'b00, 2'b00, 0, 0, 32'h0,         1, 1, 32'h0,         4'b0000, 3'd2));

        foreach (vecs[i]) begin
            run_txn(vecs[i].t, r);
            check_result($sformatf("vec%0d", i), vecs[i].t, r, vecs[i].e_rdata, vecs[i].e_err,
                         vecs[i].e_lat, vecs[i].e_wdata, vecs[i].e_strb, vecs[i].e_size);
        end

        // Reset while the load waits in RDATA.
        @(negedge clock);
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0100; req_size = 3'd2;
        @(negedge clock);
        req_valid = 1'b0;
        check("rst_mid.ar_valid", 32'(bus.data_addr_r_valid), 32'd1);
        bus.data_addr_r_ready = 1'b1;
        @(negedge clock);
        bus.data_addr_r_ready = 1'b0;
        check("rst_mid.r_ready", 32'(bus.data_r_ready), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst_mid.r_ready_after", 32'(bus.data_r_ready), 32'd0);
        check("rst_mid.resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mid.req_ready", 32'(req_ready), 32'd1);
        check("rst_mid.ar_valid_after", 32'(bus.data_addr_r_valid), 32'd0);

        // Randomized transactions against the reference model.
        for (int i = 0; i < 150; i++) begin
            txn_t        t;
            int          n;
            bit          mis;
            logic [31:0] e_rdata;
            logic        e_err;
            int          e_lat;
            t.wen   = 1'($urandom);
            t.addr  = $urandom;
            t.wdata = $urandom;
            t.size  = 3'($urandom_range(0, 3));
            t.uns   = 1'($urandom);
            t.sdata = $urandom;
            t.rresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            t.bresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            t.ar_d  = $urandom_range(0, 3);
            t.r_d   = $urandom_range(0, 3);
            t.aw_d  = $urandom_range(0, 3);
            t.w_d   = $urandom_range(0, 3);
            t.b_d   = $urandom_range(0, 3);
            t.hold  = $urandom_range(0, 2);
            run_txn(t, r);
            n   = ref_bytes(t.size);
            mis = ref_mis(t.addr, n);
            e_err   = mis ? 1'b1 : t.wen ? (t.bresp != 2'b00) : (t.rresp != 2'b00);
            e_rdata = (mis || t.wen) ? 32'h0 : ref_load(t.addr, n, t.uns, t.sdata);
            e_lat   = mis ? 1 : t.wen ? 3 + ((t.aw_d > t.w_d) ? t.aw_d : t.w_d) + t.b_d
                                      : 3 + t.ar_d + t.r_d;
            check_result($sformatf("rnd%0d", i), t, r, e_rdata, e_err, e_lat,
                         ref_wdata(t.wdata, n), ref_strb(t.addr, n), ref_size(n));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
